// File: rtl/arm_fwd_pkg.sv
// Shared types for the ARM forwarding/interlock scoreboard: producer classes,
// scoreboard entry layout and the class-to-ready-stage mapping.
package arm_fwd_pkg;

    typedef enum logic [1:0] {
        PROD_NONE,
        PROD_ALU,
        PROD_LOAD,
        PROD_MAC
    } prod_class_t;

    // Wide enough for any ready stage up to 15 stages past decode.
    localparam int STAGE_W = 4;

    localparam logic [3:0] REG_PC = 4'hF;

    typedef struct packed {
        logic               vld;
        logic               we;
        logic [3:0]         num;
        logic [STAGE_W-1:0] rdy_stage;
    } sb_entry_t;

    function automatic logic [STAGE_W-1:0] class_rdy_stage(
        input prod_class_t cls,
        input int          load_ready,
        input int          mac_latency
    );
        case (cls)
            PROD_LOAD: return STAGE_W'(load_ready);
            PROD_MAC:  return STAGE_W'(mac_latency);
            default:   return STAGE_W'(1);
        endcase
    endfunction

endpackage

// File: rtl/arm_fwd_port_check.sv
// One decode read port checked against the whole scoreboard: picks the youngest
// matching producer and reports whether its result is not yet forwardable.
module arm_fwd_port_check
    import arm_fwd_pkg::*;
#(
    parameter int NUM_STAGES = 3,
    parameter int FSEL_W     = $clog2(NUM_STAGES + 1)
) (
    input  sb_entry_t [NUM_STAGES:1] sb,
    input  logic                     rd_en,
    input  logic [3:0]               rd_num,
    output logic [FSEL_W-1:0]        fwd_sel,
    output logic                     blocked
);

    logic found;

    // NOTE: every variable in an always_comb gets a default before any branch;
    // a path that leaves one unassigned would infer a latch.
    always_comb begin
        found   = 1'b0;
        fwd_sel = '0;
        blocked = 1'b0;
        for (int k = 1; k <= NUM_STAGES; k++) begin
            // Once the youngest match is found, older entries are stale and ignored.
            if (!found && rd_en && (rd_num != REG_PC) &&
                sb[k].vld && sb[k].we && (sb[k].num == rd_num)) begin
                found = 1'b1;
                if (k >= int'(sb[k].rdy_stage)) begin
                    fwd_sel = FSEL_W'(k);
                end else begin
                    blocked = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/arm_fwd_scoreboard.sv
// Forwarding/interlock unit: shift-register scoreboard of in-flight destinations,
// per-port operand select, decode stall and a saturating stall-cycle counter.
module arm_fwd_scoreboard
    import arm_fwd_pkg::*;
#(
    parameter  int NUM_RD_PORTS = 3,
    parameter  int NUM_STAGES   = 3,
    parameter  int MAC_LATENCY  = 2,
    parameter  int LOAD_READY   = 2,
    localparam int FSEL_W       = $clog2(NUM_STAGES + 1)
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    id_valid,
    input  logic [NUM_RD_PORTS-1:0][3:0]            id_rd_num,
    input  logic [NUM_RD_PORTS-1:0]                 id_rd_mask,
    input  logic                                    id_wr_we,
    input  logic [3:0]                              id_wr_num,
    input  prod_class_t                             id_wr_class,
    input  logic                                    pipe_hold,
    input  logic                                    flush,
    output logic [NUM_RD_PORTS-1:0][FSEL_W-1:0]     fwd_sel,
    output logic                                    id_stall,
    output logic [15:0]                             stall_count
);

    sb_entry_t [NUM_STAGES:1] sb_q, sb_d;
    logic [15:0]              stall_count_q, stall_count_d;
    logic [NUM_RD_PORTS-1:0]  blocked;
    sb_entry_t                new_entry;

    for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_port
        arm_fwd_port_check #(
            .NUM_STAGES (NUM_STAGES),
            .FSEL_W     (FSEL_W)
        ) u_port_check (
            .sb      (sb_q),
            .rd_en   (id_rd_mask[p]),
            .rd_num  (id_rd_num[p]),
            .fwd_sel (fwd_sel[p]),
            .blocked (blocked[p])
        );
    end

    assign id_stall    = id_valid & (|blocked) & ~flush;
    assign stall_count = stall_count_q;

    always_comb begin
        new_entry = '{vld:       id_valid,
                      we:        id_wr_we,
                      num:       id_wr_num,
                      rdy_stage: class_rdy_stage(id_wr_class, LOAD_READY, MAC_LATENCY)};
        sb_d          = sb_q;
        stall_count_d = stall_count_q;
        if (flush) begin
            for (int k = 1; k <= NUM_STAGES; k++) begin
                sb_d[k].vld = 1'b0;
            end
        end else if (!pipe_hold) begin
            for (int k = NUM_STAGES; k >= 2; k--) begin
                sb_d[k] = sb_q[k-1];
            end
            if (id_stall) begin
                // Bubble into EX; the stalled instruction is re-presented next cycle.
                sb_d[1] = '0;
                if (stall_count_q != 16'hFFFF) begin
                    stall_count_d = stall_count_q + 16'd1;
                end
            end else begin
                sb_d[1] = new_entry;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q          <= '0;
            stall_count_q <= '0;
        end else begin
            sb_q          <= sb_d;
            stall_count_q <= stall_count_d;
        end
    end

endmodule
